// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory link between the fetch unit and imem.
// master: fetch side drives requests; slave: memory side answers.
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, credit-limited imem requests, DEPTH-entry word FIFO.
// Ports: CLOCK_50/reset, imem link (if), ins/ins_pc/ins_valid/ins_ready, redirect/redirect_pc, fifo_count.
module instr_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  instr_fetch_unit_if.master       imem,
  output logic [31:0]              ins,
  output logic [31:0]              ins_pc,
  output logic                     ins_valid,
  input  logic                     ins_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] CAP = DEPTH[CW:0];

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fetch_ent_t;

  fetch_ent_t  fbuf [DEPTH];
  fetch_ent_t  head;

  logic [31:0] fpc, fpc_n;
  logic [31:0] rsp_pc, rsp_pc_n;
  logic [31:0] last_ins, last_ins_n;
  logic [31:0] last_pc, last_pc_n;
  logic [31:0] tgt;
  cnt_t        outstanding, out_n;
  cnt_t        drop_cnt, drop_n;
  cnt_t        count, count_n;
  ptr_t        wptr, wptr_n;
  ptr_t        rptr, rptr_n;
  logic [CW:0] in_use;
  logic        req_fire, rsp_fire, push, pop;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];
  assign tgt    = {redirect_pc[31:2], 2'b00};
  assign in_use = {1'b0, outstanding} + {1'b0, count};

  // Credits cover both in-flight words and buffered ones, so the
  // FIFO can never be overrun by returning data.
  assign imem.imem_req_valid = !reset && !redirect &&
                               drop_cnt == '0 && in_use < CAP;
  assign imem.imem_req_addr  = fpc;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_fire = imem.imem_rsp_valid && outstanding != '0;
  assign push     = rsp_fire && !redirect && drop_cnt == '0;

  assign head       = fbuf[rptr];
  assign ins_valid  = count != '0;
  assign pop        = ins_valid && ins_ready;
  assign ins        = ins_valid ? head.data : last_ins;
  assign ins_pc     = ins_valid ? head.pc : last_pc;
  assign fifo_count = count;

  always_comb begin
    fpc_n      = fpc;
    rsp_pc_n   = rsp_pc;
    drop_n     = drop_cnt;
    count_n    = count;
    wptr_n     = wptr;
    rptr_n     = rptr;
    out_n      = outstanding + cnt_t'(req_fire) - cnt_t'(rsp_fire);
    last_ins_n = ins;
    last_pc_n  = ins_pc;
    if (redirect) begin
      // No request fires here, so out_n is what is still in flight.
      fpc_n    = tgt;
      rsp_pc_n = tgt;
      drop_n   = out_n;
      count_n  = '0;
      wptr_n   = '0;
      rptr_n   = '0;
    end else begin
      if (req_fire)
        fpc_n = fpc + 32'd4;
      if (rsp_fire && drop_cnt != '0)
        drop_n = drop_cnt - cnt_t'(1);
      if (push) begin
        wptr_n   = wptr + ptr_t'(1);
        rsp_pc_n = rsp_pc + 32'd4;
      end
      if (pop)
        rptr_n = rptr + ptr_t'(1);
      count_n = count + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      fpc         <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wptr        <= '0;
      rptr        <= '0;
      last_ins    <= '0;
      last_pc     <= '0;
    end else begin
      fpc         <= fpc_n;
      rsp_pc      <= rsp_pc_n;
      outstanding <= out_n;
      drop_cnt    <= drop_n;
      count       <= count_n;
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      last_ins    <= last_ins_n;
      last_pc     <= last_pc_n;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && push)
      fbuf[wptr] <= '{pc: rsp_pc, data: imem.imem_rsp_data};
  end

  a_rsp_credit: assert property (
    @(posedge CLOCK_50) disable iff (reset)
    imem.imem_rsp_valid |-> outstanding != '0
  );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based fetch model, latency memory,
// directed corner sequences, a redirect-target table and random traffic.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        CLOCK_50 = 1'b0;
  logic        reset, ins_valid, ins_ready, redirect;
  logic [31:0] ins, ins_pc, redirect_pc;
  logic [2:0]  fifo_count;

  instr_fetch_unit_if imem();

  instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .imem       (imem),
    .ins        (ins),
    .ins_pc     (ins_pc),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fifo_count (fifo_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] a0;
    logic [31:0] a1;
  } redir_vec_t;

  int          n_tests, n_fail, cyc, n_req;
  int          m_out, m_drop;
  bit          m_init;
  logic [31:0] m_fpc, m_last_ins, m_last_pc;
  logic [31:0] q[$];
  pend_t       pend[$];
  bit          t_reset, t_redir, t_ready, t_ins_ready;
  int          t_lat;
  logic [31:0] t_rpc;
  bit          rsp, exp_rv, act_rv;
  logic [31:0] rsp_addr;
  redir_vec_t  vec [5];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic drive_check();
    logic [31:0] e_pc, e_ins;
    @(negedge CLOCK_50);
    reset = t_reset;
    redirect = t_redir;
    redirect_pc = t_rpc;
    ins_ready = t_ins_ready;
    imem.imem_req_ready = t_ready;
    rsp = 1'b0;
    rsp_addr = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp = 1'b1;
      rsp_addr = pend[0].addr;
      void'(pend.pop_front());
    end
    imem.imem_rsp_valid = rsp;
    imem.imem_rsp_data = rsp ? word(rsp_addr) : $urandom;
    exp_rv = !t_reset && !t_redir && m_drop == 0 && (m_out + q.size()) < DEPTH;
    #1;
    act_rv = imem.imem_req_valid;
    if (m_init) begin
      e_pc = m_last_pc;
      e_ins = m_last_ins;
      if (q.size() > 0) begin
        e_pc = q[0];
        e_ins = word(q[0]);
      end
      chk("req_valid", 32'(act_rv), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem.imem_req_addr, m_fpc);
      chk("ins_valid", 32'(ins_valid), 32'(q.size() > 0));
      chk("ins_pc", ins_pc, e_pc);
      chk("ins", ins, e_ins);
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
    end
  endtask

  task automatic edge_update();
    pend_t p;
    int lat;
    @(posedge CLOCK_50);
    if (t_reset) begin
      m_fpc = RESET_PC;
      q.delete();
      pend.delete();
      m_out = 0;
      m_drop = 0;
      m_last_ins = '0;
      m_last_pc = '0;
      m_init = 1'b1;
    end else begin
      if (act_rv && t_ready) n_req++;
      if (q.size() > 0) begin
        m_last_pc = q[0];
        m_last_ins = word(q[0]);
        if (t_ins_ready) void'(q.pop_front());
      end
      if (rsp) begin
        m_out--;
        if (!t_redir) begin
          if (m_drop > 0) m_drop--;
          else q.push_back(rsp_addr);
        end
      end
      if (t_redir) begin
        q.delete();
        m_drop = m_out;
        m_fpc = {t_rpc[31:2], 2'b00};
      end else if (exp_rv && t_ready) begin
        lat = (t_lat == 0) ? int'($urandom_range(4, 1)) : t_lat;
        p.addr = m_fpc;
        p.due = cyc + lat;
        pend.push_back(p);
        m_fpc = m_fpc + 32'd4;
        m_out++;
      end
    end
    cyc++;
  endtask

  task automatic cycle();
    drive_check();
    edge_update();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_ins(input int bound, input logic [31:0] exp_pc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      drive_check();
      if (ins_valid) begin
        seen = 1'b1;
        chk(nm, ins_pc, exp_pc);
      end
      edge_update();
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: ins_valid never rose within %0d cycles", nm, bound);
    end
  endtask

  initial begin
    int n0;
    n_tests = 0; n_fail = 0; cyc = 0; n_req = 0;
    m_init = 1'b0; m_out = 0; m_drop = 0;
    m_fpc = RESET_PC; m_last_ins = '0; m_last_pc = '0;
    vec[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104};
    vec[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
    vec[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vec[3] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vec[4] = '{32'h8000_0001, 32'h8000_0000, 32'h8000_0004};

    t_reset = 1; t_redir = 0; t_rpc = '0;
    t_ready = 1; t_lat = 1; t_ins_ready = 1;
    run(2);
    t_reset = 0;
    drive_check();
    chk("rst_req_valid", 32'(act_rv), 32'd1);
    chk("rst_addr", imem.imem_req_addr, RESET_PC);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
    edge_update();

    wait_ins(5, RESET_PC, "t1_first_pc");
    for (int i = 1; i <= 8; i++) begin
      drive_check();
      chk("t1_valid", 32'(ins_valid), 32'd1);
      chk("t1_pc", ins_pc, RESET_PC + 32'(i * 4));
      edge_update();
    end

    t_ready = 0;
    run(6);
    t_ins_ready = 0;
    t_ready = 1;
    n0 = n_req;
    run(10);
    drive_check();
    chk("t2_count", 32'(fifo_count), 32'd4);
    chk("t2_req_valid", 32'(act_rv), 32'd0);
    chk("t2_nreq", 32'(n_req - n0), 32'd4);
    edge_update();
    t_ins_ready = 1;
    n0 = n_req;
    cycle();
    t_ins_ready = 0;
    run(4);
    chk("t2_one_per_pop", 32'(n_req - n0), 32'd1);

    t_ins_ready = 1;
    t_ready = 0;
    run(8);
    t_ready = 1;
    t_lat = 4;
    run(3);
    t_ready = 0;
    t_redir = 1;
    t_rpc = 32'h100;
    drive_check();
    chk("t3_no_rsp", 32'(imem.imem_rsp_valid), 32'd0);
    edge_update();
    t_redir = 0;
    t_ready = 1;
    t_lat = 1;
    for (int i = 0; i < 3; i++) begin
      drive_check();
      chk("t3_hold_req", 32'(act_rv), 32'd0);
      edge_update();
    end
    wait_ins(10, 32'h100, "t3_pc");

    t_lat = 1; t_ready = 1; t_ins_ready = 1;
    run(6);
    t_redir = 1;
    t_rpc = 32'h200;
    drive_check();
    chk("t4_popping", 32'(ins_valid), 32'd1);
    edge_update();
    t_redir = 0;
    drive_check();
    chk("t4_empty", 32'(fifo_count), 32'd0);
    chk("t4_addr", imem.imem_req_addr, 32'h200);
    chk("t4_req_valid", 32'(act_rv), 32'd1);
    edge_update();
    wait_ins(6, 32'h200, "t4_pc");

    t_ready = 0;
    run(4);
    foreach (vec[k]) begin
      t_redir = 1; t_rpc = vec[k].rpc; t_ready = 0;
      cycle();
      t_redir = 0; t_ready = 1;
      drive_check();
      chk("t5_addr0", imem.imem_req_addr, vec[k].a0);
      edge_update();
      t_ready = 0;
      drive_check();
      chk("t5_addr1", imem.imem_req_addr, vec[k].a1);
      edge_update();
      run(3);
    end

    t_ins_ready = 1; t_ready = 1; t_lat = 3;
    run(2);
    t_ready = 0;
    cycle();
    t_reset = 1;
    cycle();
    t_reset = 0;
    drive_check();
    chk("t6_req_valid", 32'(act_rv), 32'd1);
    chk("t6_addr", imem.imem_req_addr, RESET_PC);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_ins_valid", 32'(ins_valid), 32'd0);
    chk("t6_ins", ins, 32'd0);
    chk("t6_ins_pc", ins_pc, 32'd0);
    edge_update();
    t_ready = 1; t_lat = 1;
    wait_ins(6, RESET_PC, "t6_pc");

    t_lat = 0;
    repeat (3000) begin
      t_ready = $urandom_range(3, 0) != 0;
      t_ins_ready = $urandom_range(1, 0) != 0;
      t_redir = $urandom_range(19, 0) == 0;
      t_rpc = $urandom;
      t_reset = $urandom_range(299, 0) == 0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
